// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for eight requesters sharing one one-hot select resource.
// Define ARB_TIMEOUT_EN to revoke grants held for MAX_HOLD cycles (timeout pulse).
module rr_arbiter8 #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       req,
    output logic             gnt_valid,
    output logic [2:0]       gnt_idx,
    output logic [7:0]       gnt_onehot,
    output logic             timeout,
    output logic             fsm_state,
    output logic [CNT_W-1:0] hold_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    if (MAX_HOLD < 2 || MAX_HOLD > 255 || (1 << CNT_W) <= MAX_HOLD) begin : g_param_check
        $error("rr_arbiter8: MAX_HOLD must be 2..255 and fit in CNT_W bits");
    end

    state_t           state, state_n;
    logic [2:0]       ptr, ptr_n;
    logic [2:0]       gnt_idx_n;
    logic [7:0]       gnt_onehot_n;
    logic             gnt_valid_n;
    logic             timeout_n;
    logic [CNT_W-1:0] cnt_n;
    logic [2:0]       win_idx;
    logic [2:0]       cand;
    logic             found;

    assign fsm_state = state;

    // Scan ptr+1, ptr+2, ... so the last owner gets the lowest priority.
    always_comb begin
        win_idx = '0;
        cand    = '0;
        found   = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            cand = ptr + 3'(i);
            if (!found && req[cand]) begin
                win_idx = cand;
                found   = 1'b1;
            end
        end
    end

    always_comb begin
        state_n      = state;
        ptr_n        = ptr;
        gnt_valid_n  = gnt_valid;
        gnt_idx_n    = gnt_idx;
        gnt_onehot_n = gnt_onehot;
        cnt_n        = hold_cnt;
        timeout_n    = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_n      = GRANT;
                    gnt_valid_n  = 1'b1;
                    gnt_idx_n    = win_idx;
                    gnt_onehot_n = 8'b1 << win_idx;
                    cnt_n        = CNT_W'(1);
                end
            end
            GRANT: begin
                if (!req[gnt_idx]) begin
                    state_n      = IDLE;
                    ptr_n        = gnt_idx;
                    gnt_valid_n  = 1'b0;
                    gnt_idx_n    = '0;
                    gnt_onehot_n = '0;
                    cnt_n        = '0;
                end
`ifdef ARB_TIMEOUT_EN
                else if (hold_cnt == CNT_W'(MAX_HOLD)) begin
                    state_n      = IDLE;
                    ptr_n        = gnt_idx;
                    gnt_valid_n  = 1'b0;
                    gnt_idx_n    = '0;
                    gnt_onehot_n = '0;
                    cnt_n        = '0;
                    timeout_n    = 1'b1;
                end
`endif
                else if (hold_cnt != '1) begin
                    cnt_n = hold_cnt + CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= 3'd7;
            gnt_valid  <= 1'b0;
            gnt_idx    <= '0;
            gnt_onehot <= '0;
            timeout    <= 1'b0;
            hold_cnt   <= '0;
        end else begin
            state      <= state_n;
            ptr        <= ptr_n;
            gnt_valid  <= gnt_valid_n;
            gnt_idx    <= gnt_idx_n;
            gnt_onehot <= gnt_onehot_n;
            timeout    <= timeout_n;
            hold_cnt   <= cnt_n;
        end
    end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8: directed scenarios plus random request traffic
// compared cycle by cycle against a behavioural round-robin model.
module tb_rr_arbiter8;

    localparam int TB_MAX_HOLD = 4;
    localparam int TB_CNT_W    = 8;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [7:0]          req = '0;
    logic                gnt_valid;
    logic [2:0]          gnt_idx;
    logic [7:0]          gnt_onehot;
    logic                timeout;
    logic                fsm_state;
    logic [TB_CNT_W-1:0] hold_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: owner -1 means nobody holds the resource.
    int m_owner;
    int m_ptr;
    int m_hold;
    bit m_timeout;

    logic [7:0] exp_q[$];

    rr_arbiter8 #(.MAX_HOLD(TB_MAX_HOLD), .CNT_W(TB_CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .gnt_valid  (gnt_valid),
        .gnt_idx    (gnt_idx),
        .gnt_onehot (gnt_onehot),
        .timeout    (timeout),
        .fsm_state  (fsm_state),
        .hold_cnt   (hold_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner   = -1;
        m_ptr     = 7;
        m_hold    = 0;
        m_timeout = 0;
    endtask

    task automatic model_edge(input logic [7:0] r);
        bit done;
        int c;
        m_timeout = 0;
        if (m_owner < 0) begin
            done = 0;
            for (int k = 1; k <= 8; k++) begin
                c = (m_ptr + k) % 8;
                if (!done && r[c]) begin
                    m_owner = c;
                    m_hold  = 1;
                    done    = 1;
                end
            end
        end else if (!r[m_owner]) begin
            m_ptr   = m_owner;
            m_owner = -1;
        end else begin
`ifdef ARB_TIMEOUT_EN
            if (m_hold == TB_MAX_HOLD) begin
                m_ptr     = m_owner;
                m_owner   = -1;
                m_timeout = 1;
            end else
`endif
            m_hold++;
        end
    endtask

    task automatic check_model(input string tag);
        logic [7:0] oh;
        oh = (m_owner >= 0) ? (8'b1 << m_owner) : 8'h00;
        check_eq({tag, ".valid"}, 32'(gnt_valid), 32'(m_owner >= 0));
        check_eq({tag, ".idx"}, 32'(gnt_idx), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
        check_eq({tag, ".onehot"}, 32'(gnt_onehot), 32'(oh));
        check_eq({tag, ".timeout"}, 32'(timeout), 32'(m_timeout));
    endtask

    // Called at a negedge: drive, take one active edge, check at the next negedge.
    task automatic step(input logic [7:0] r, input string tag);
        req = r;
        @(posedge clk);
        model_edge(r);
        @(negedge clk);
        check_model(tag);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_model(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [7:0] rv;

    initial begin
        model_reset();
        @(negedge clk);
        check_model("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Single requester grant and release.
        step(8'h01, "single_on");
        check_eq("single_idx", 32'(gnt_idx), 32'd0);
        check_eq("single_oh", 32'(gnt_onehot), 32'h01);
        step(8'h00, "single_off");

        // Full rotation 0..7,0 with each owner releasing one cycle after its grant.
        do_reset("reset2");
        for (int i = 0; i < 9; i++) exp_q.push_back(8'(i % 8));
        for (int i = 0; i < 9; i++) begin
            step(8'hFF, "rot_grant");
            check_eq("rot_order", 32'(gnt_idx), 32'(exp_q.pop_front()));
            step(8'hFF & ~(8'b1 << gnt_idx), "rot_release");
            check_eq("rot_gap", 32'(gnt_valid), 32'd0);
        end

        // Wrap past 7 from ptr=3, then continue from ptr=0.
        do_reset("reset3");
        step(8'h08, "wrap_g3");
        step(8'h00, "wrap_rel3");
        step(8'h05, "wrap_g0");
        check_eq("wrap_winner0", 32'(gnt_idx), 32'd0);
        step(8'h04, "wrap_rel0");
        step(8'h05, "wrap_g2");
        check_eq("wrap_winner2", 32'(gnt_idx), 32'd2);

        // Owner 5 holds while everyone else requests.
        do_reset("reset4");
        step(8'h20, "hold_g5");
        for (int i = 0; i < 20; i++) begin
            step(8'hFF, "hold5");
`ifndef ARB_TIMEOUT_EN
            check_eq("hold5_idx", 32'(gnt_idx), 32'd5);
            check_eq("hold5_oh", 32'(gnt_onehot), 32'h20);
`endif
        end

        // Long hold with two requesters.
        do_reset("reset5");
`ifdef ARB_TIMEOUT_EN
        for (int i = 0; i < TB_MAX_HOLD; i++) begin
            step(8'h03, "to_hold");
            check_eq("to_owner0", 32'(gnt_idx), 32'd0);
            check_eq("to_valid", 32'(gnt_valid), 32'd1);
        end
        step(8'h03, "to_revoke");
        check_eq("to_pulse", 32'(timeout), 32'd1);
        check_eq("to_idle", 32'(gnt_valid), 32'd0);
        step(8'h03, "to_next");
        check_eq("to_next1", 32'(gnt_idx), 32'd1);
        check_eq("to_pulse_end", 32'(timeout), 32'd0);
`else
        for (int i = 0; i < 10; i++) begin
            step(8'h03, "nto_hold");
            check_eq("nto_owner0", 32'(gnt_idx), 32'd0);
            check_eq("nto_timeout", 32'(timeout), 32'd0);
        end
`endif

        // Asynchronous reset in the middle of a grant to 6.
        do_reset("reset6");
        step(8'h40, "mid_g6");
        check_eq("mid_owner6", 32'(gnt_idx), 32'd6);
        #2;
        do_reset("mid_async");
        step(8'h41, "mid_after");
        check_eq("mid_winner0", 32'(gnt_idx), 32'd0);

        // Random traffic: each request bit toggles occasionally so holds vary in length.
        do_reset("reset7");
        rv = '0;
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < 8; b++)
                if ($urandom_range(0, 5) == 0) rv[b] = ~rv[b];
            step(rv, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
